pht_update_scheduler: RTL and testbench
=======================================

// Module: pht_update_scheduler
// PURPOSE
// - Sole write-port owner of a single-write-port per-address PHT (2^INDEX_W entries of CTR_W-bit counters).
// - Accepts up to IN_NUM branch-result counter updates per cycle and buffers them in an in-order FIFO.
// - Drains the FIFO at one saturating-counter write per cycle, so the table never sees a same-bank write conflict.
// - After reset, runs the table initialisation sweep before accepting any update.
// PARAMETERS
// - INDEX_W      9   PHT index width; table has 2^INDEX_W entries
// - CTR_W        2   saturating counter width
// - IN_NUM       2   update ports per cycle (matches INT_ISSUE_WIDTH)
// - QUEUE_DEPTH  8   FIFO entries; power of two, >= 2*IN_NUM
// PORTS
// - clk           in   1              clock
// - rst           in   1              asynchronous reset, active-low
// - updValid      in   IN_NUM         port i carries a resolved conditional-branch update
// - updIndex      in   IN_NUM*INDEX_W PHT index of port i
// - updTaken      in   IN_NUM         branch outcome of port i
// - updPrevCtr    in   IN_NUM*CTR_W   counter value read at predict time for port i
// - updReady      out  1              FIFO has >= IN_NUM free entries and state==RUN
// - tblWE         out  1              table write enable
// - tblWA         out  INDEX_W        table write address
// - tblWV         out  CTR_W          table write value
// - initBusy      out  1              initialisation sweep in progress
// - overflow      out  1              sticky: an update was dropped
// BEHAVIOUR
// - Reset (rst=0, async): FIFO empty; state=INIT; sweep index=0; overflow=0.
//   Outputs while in INIT: initBusy=1, updReady=0, tblWE=1.
// - State INIT: tblWA=sweep index; tblWV=2^(CTR_W-1) (weakly taken). Sweep index +1 per cycle.
//   After index 2^INDEX_W-1 is written, go to RUN. INIT lasts exactly 2^INDEX_W cycles.
// - State RUN: initBusy=0. tblWE=1 iff FIFO non-empty. tblWA/tblWV come combinationally from the FIFO head; head pops on the same edge.
// - Enqueue order within one cycle: ascending port number.
// - Each entry stores {index, newCtr}:
//   - newCtr = updTaken ? min(prev+1, 2^CTR_W-1) : max(prev-1, 0).
//   - No wrap at either end.
// - Latency: an update accepted at edge N is written at cycle N+1 if the FIFO was empty; otherwise after all older entries.
// - Dropped update: updValid=1 while updReady=0 (including INIT) is dropped and sets overflow. Only rst clears overflow.
// - Simultaneous push and pop: allowed; occupancy changes by pushes-1.
// - Full: updReady falls when free entries < IN_NUM, evaluated on post-pop occupancy of the current cycle.
// - Pointers wrap modulo QUEUE_DEPTH.
// - Occupancy counter is log2(QUEUE_DEPTH)+1 bits and never exceeds QUEUE_DEPTH.
// - Reset mid-sweep or with a non-empty FIFO: restarts INIT from index 0 and discards every queued entry.
// CONFIGURATION
// - PHT_UPDATE_MERGE_EN defined:
//   - Same-cycle updates with equal index are merged into one entry. Port 0 steps prev first, then port 1 steps that result.
//   - An incoming update whose index equals the FIFO tail entry (not the head being popped) is folded into the tail: its step is applied to the tail's newCtr.
//   - Merged updates consume no extra FIFO entry.
// - PHT_UPDATE_MERGE_EN undefined:
//   - Every valid update occupies its own entry; each uses its own updPrevCtr.
//   - Equal-index updates are written in order, so the last write wins.
// TESTING
// - Reset, hold: initBusy=1 for exactly 512 cycles. tblWA goes 0..511 with tblWV=2 (binary 10). Then initBusy=0, updReady=1, tblWE=0.
// - RUN, empty FIFO: port0 {idx 5, taken, prev 3} -> next cycle tblWE=1, WA=5, WV=3 (saturates high).
//   Then port0 {idx 6, not taken, prev 0} -> WV=0 (saturates low).
// - Same cycle, port0 {idx 9, T, prev 1} and port1 {idx 9, T, prev 1}:
//   - Merge on: one write, WA=9, WV=3.
//   - Merge off: two writes WA=9 with WV=2 then 2.
// - 8 cycles of dual updates to distinct indices, no merge:
//   - updReady falls once occupancy leaves < 2 free entries.
//   - An update presented after updReady falls sets overflow=1 and is never written.
//   - Writes appear in acceptance order.
// - Assert rst mid-sweep (index 100) with 3 entries queued -> sweep restarts at 0; none of the 3 entries is ever written.

Source files
------------

// File: rtl/pht_update_scheduler_if.sv
// Update/table bus for the PHT update scheduler.
// Producer side (issue/resolve logic and PHT write port) uses modport master;
// the scheduler uses modport slave.
interface pht_update_scheduler_if #(
    parameter int INDEX_W = 9,
    parameter int CTR_W   = 2,
    parameter int IN_NUM  = 2
);
    logic [IN_NUM-1:0]         updValid;
    logic [IN_NUM*INDEX_W-1:0] updIndex;
    logic [IN_NUM-1:0]         updTaken;
    logic [IN_NUM*CTR_W-1:0]   updPrevCtr;
    logic                      updReady;
    logic                      tblWE;
    logic [INDEX_W-1:0]        tblWA;
    logic [CTR_W-1:0]          tblWV;
    logic                      initBusy;
    logic                      overflow;

    modport master (
        output updValid, updIndex, updTaken, updPrevCtr,
        input  updReady, tblWE, tblWA, tblWV, initBusy, overflow
    );

    modport slave (
        input  updValid, updIndex, updTaken, updPrevCtr,
        output updReady, tblWE, tblWA, tblWV, initBusy, overflow
    );
endinterface

// File: rtl/pht_update_scheduler.sv
// PHT update scheduler: sole owner of the PHT write port.
// Buffers up to IN_NUM counter updates per cycle in an in-order FIFO and
// drains one saturating-counter write per cycle. After reset it sweeps the
// whole table to weakly-taken before accepting updates.
// Optional build macro PHT_UPDATE_MERGE_EN: equal-index updates in the same
// cycle, or matching the FIFO tail entry, are folded into a single entry.
//
// state   | meaning
// ST_INIT | table sweep, one weakly-taken write per cycle, updates dropped
// ST_RUN  | accept updates, pop one FIFO entry per cycle to the table
module pht_update_scheduler #(
    parameter int INDEX_W     = 9,
    parameter int CTR_W       = 2,
    parameter int IN_NUM      = 2,
    parameter int QUEUE_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    pht_update_scheduler_if.slave    bus
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [INDEX_W-1:0] r_sweep;
    logic [INDEX_W-1:0] r_q_idx [QUEUE_DEPTH];
    logic [CTR_W-1:0]   r_q_ctr [QUEUE_DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;

    logic               w_pop;
    logic               w_ready;
    logic [CNT_W-1:0]   w_n_push;
    logic               w_push_en  [IN_NUM];
    logic [INDEX_W-1:0] w_push_idx [IN_NUM];
    logic [CTR_W-1:0]   w_push_ctr [IN_NUM];
    logic [PTR_W-1:0]   w_push_ptr [IN_NUM];
`ifdef PHT_UPDATE_MERGE_EN
    logic [PTR_W-1:0]   w_tail_ptr;
    logic               w_tail_ok;
    logic               w_fold;
    logic [CTR_W-1:0]   w_fold_ctr;
`endif

    function automatic logic [CTR_W-1:0] f_step(input logic [CTR_W-1:0] c, input logic t);
        if (t) return (c == CTR_MAX) ? c : c + CTR_W'(1);
        else   return (c == '0)      ? c : c - CTR_W'(1);
    endfunction

    // State register and sweep index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_INIT;
            r_sweep <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) r_sweep <= r_sweep + INDEX_W'(1);
        end
    end

    // Next state, table write port and update acceptance.
    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_ready      = 1'b0;
        bus.tblWE    = 1'b0;
        bus.tblWA    = r_q_idx[r_rptr];
        bus.tblWV    = r_q_ctr[r_rptr];
        bus.initBusy = 1'b0;
        case (r_state)
            ST_INIT: begin
                bus.initBusy = 1'b1;
                bus.tblWE    = 1'b1;
                bus.tblWA    = r_sweep;
                bus.tblWV    = CTR_WEAK;
                if (r_sweep == '1) w_state_nxt = ST_RUN;
            end
            default: begin
                w_pop     = (r_count != '0);
                bus.tblWE = w_pop;
                // free entries after this cycle's pop
                w_ready   = (CNT_W'(QUEUE_DEPTH) - r_count + CNT_W'(w_pop)) >= CNT_W'(IN_NUM);
            end
        endcase
    end

    assign bus.updReady = w_ready;
    assign bus.overflow = r_overflow;

`ifdef PHT_UPDATE_MERGE_EN
    assign w_tail_ptr = r_wptr - PTR_W'(1);
    // the tail may only absorb an update if it is not the head leaving this cycle
    assign w_tail_ok  = (r_count - CNT_W'(w_pop)) != '0;
`endif

    // Slot allocation for this cycle's accepted updates, ascending port order.
    always_comb begin
        logic [CNT_W-1:0]   n;
        logic [INDEX_W-1:0] idx;
        logic [CTR_W-1:0]   stepped;
`ifdef PHT_UPDATE_MERGE_EN
        int                 last;
        last       = 0;
        w_fold     = 1'b0;
        w_fold_ctr = r_q_ctr[w_tail_ptr];
`endif
        n = '0;
        for (int i = 0; i < IN_NUM; i++) begin
            w_push_en[i]  = 1'b0;
            w_push_idx[i] = '0;
            w_push_ctr[i] = '0;
            w_push_ptr[i] = r_wptr;
        end
        for (int i = 0; i < IN_NUM; i++) begin
            idx     = bus.updIndex[i*INDEX_W +: INDEX_W];
            stepped = f_step(bus.updPrevCtr[i*CTR_W +: CTR_W], bus.updTaken[i]);
            if (bus.updValid[i] && w_ready) begin
`ifdef PHT_UPDATE_MERGE_EN
                if (n != '0 && idx == w_push_idx[last]) begin
                    w_push_ctr[last] = f_step(w_push_ctr[last], bus.updTaken[i]);
                end else if (n == '0 && w_tail_ok && idx == r_q_idx[w_tail_ptr]) begin
                    w_fold     = 1'b1;
                    w_fold_ctr = f_step(w_fold_ctr, bus.updTaken[i]);
                end else begin
                    w_push_en[i]  = 1'b1;
                    w_push_idx[i] = idx;
                    w_push_ctr[i] = stepped;
                    w_push_ptr[i] = r_wptr + n[PTR_W-1:0];
                    n             = n + CNT_W'(1);
                    last          = i;
                end
`else
                w_push_en[i]  = 1'b1;
                w_push_idx[i] = idx;
                w_push_ctr[i] = stepped;
                w_push_ptr[i] = r_wptr + n[PTR_W-1:0];
                n             = n + CNT_W'(1);
`endif
            end
        end
        w_n_push = n;
    end

    // FIFO storage; stale contents are harmless because pointers define validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_NUM; i++) begin
            if (w_push_en[i]) begin
                r_q_idx[w_push_ptr[i]] <= w_push_idx[i];
                r_q_ctr[w_push_ptr[i]] <= w_push_ctr[i];
            end
        end
`ifdef PHT_UPDATE_MERGE_EN
        if (w_fold) r_q_ctr[w_tail_ptr] <= w_fold_ctr;
`endif
    end

    // Pointers, occupancy and sticky drop flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_wptr     <= r_wptr + w_n_push[PTR_W-1:0];
            r_rptr     <= r_rptr + PTR_W'(w_pop);
            r_count    <= r_count + w_n_push - CNT_W'(w_pop);
            r_overflow <= r_overflow | ((|bus.updValid) & ~w_ready);
        end
    end
endmodule

// File: tb/tb_pht_update_scheduler.sv
// Directed bench for pht_update_scheduler (default build unless noted).
module tb_pht_update_scheduler;
    localparam int INDEX_W = 9;
    localparam int CTR_W   = 2;
    localparam int IN_NUM  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_mis = 0;
    int   p;

    always #5 clk = ~clk;

    pht_update_scheduler_if #(.INDEX_W(INDEX_W), .CTR_W(CTR_W), .IN_NUM(IN_NUM)) u_if ();

    pht_update_scheduler #(.INDEX_W(INDEX_W), .CTR_W(CTR_W), .IN_NUM(IN_NUM), .QUEUE_DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_in();
        u_if.updValid   = '0;
        u_if.updIndex   = '0;
        u_if.updTaken   = '0;
        u_if.updPrevCtr = '0;
    endtask

    task automatic set_port(input int pn, input logic [INDEX_W-1:0] idx, input logic t,
                            input logic [CTR_W-1:0] prev);
        u_if.updValid[pn]                    = 1'b1;
        u_if.updIndex[pn*INDEX_W +: INDEX_W] = idx;
        u_if.updTaken[pn]                    = t;
        u_if.updPrevCtr[pn*CTR_W +: CTR_W]   = prev;
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    // Expected order: idx 18..31, even positions taken prev1 -> 2, odd not-taken prev1 -> 0.
    task automatic chk_write();
        if (u_if.tblWE) begin
            if (p < 14) begin
                check("ov_wa", 32'(u_if.tblWA), 32'(18 + p));
                check("ov_wv", 32'(u_if.tblWV), (p % 2 == 0) ? 32'd2 : 32'd0);
            end
            p++;
        end
    endtask

    initial begin
        clear_in();
        // reset values
        nxt();
        check("rst_initBusy", 32'(u_if.initBusy), 32'd1);
        check("rst_updReady", 32'(u_if.updReady), 32'd0);
        check("rst_tblWE",    32'(u_if.tblWE),    32'd1);
        check("rst_tblWA",    32'(u_if.tblWA),    32'd0);
        check("rst_tblWV",    32'(u_if.tblWV),    32'd2);
        check("rst_overflow", 32'(u_if.overflow), 32'd0);
        nxt();
        rst = 1'b1;

        // full init sweep
        for (int i = 0; i < 512; i++) begin
            check("init_busy", 32'(u_if.initBusy), 32'd1);
            check("init_wa",   32'(u_if.tblWA),    32'(i));
            check("init_wv",   32'(u_if.tblWV),    32'd2);
            nxt();
        end
        check("run_initBusy", 32'(u_if.initBusy), 32'd0);
        check("run_updReady", 32'(u_if.updReady), 32'd1);
        check("run_tblWE",    32'(u_if.tblWE),    32'd0);

        // single updates, saturation at both ends
        set_port(0, 9'd5, 1'b1, 2'd3);
        nxt();
        clear_in();
        check("sat_hi_we", 32'(u_if.tblWE), 32'd1);
        check("sat_hi_wa", 32'(u_if.tblWA), 32'd5);
        check("sat_hi_wv", 32'(u_if.tblWV), 32'd3);
        set_port(0, 9'd6, 1'b0, 2'd0);
        nxt();
        clear_in();
        check("sat_lo_we", 32'(u_if.tblWE), 32'd1);
        check("sat_lo_wa", 32'(u_if.tblWA), 32'd6);
        check("sat_lo_wv", 32'(u_if.tblWV), 32'd0);
        nxt();
        check("idle_we", 32'(u_if.tblWE), 32'd0);

        // same-cycle equal index
        set_port(0, 9'd9, 1'b1, 2'd1);
        set_port(1, 9'd9, 1'b1, 2'd1);
        nxt();
        clear_in();
`ifdef PHT_UPDATE_MERGE_EN
        check("merge_we", 32'(u_if.tblWE), 32'd1);
        check("merge_wa", 32'(u_if.tblWA), 32'd9);
        check("merge_wv", 32'(u_if.tblWV), 32'd3);
        nxt();
        check("merge_one_write", 32'(u_if.tblWE), 32'd0);
`else
        check("dup0_we", 32'(u_if.tblWE), 32'd1);
        check("dup0_wa", 32'(u_if.tblWA), 32'd9);
        check("dup0_wv", 32'(u_if.tblWV), 32'd2);
        nxt();
        check("dup1_we", 32'(u_if.tblWE), 32'd1);
        check("dup1_wa", 32'(u_if.tblWA), 32'd9);
        check("dup1_wv", 32'(u_if.tblWV), 32'd2);
        nxt();
        check("dup_done_we", 32'(u_if.tblWE), 32'd0);
`endif

        // 8 cycles of dual distinct updates: 7 accepted, 8th dropped
        check("pre_ov_overflow", 32'(u_if.overflow), 32'd0);
        p = 0;
        for (int k = 1; k <= 8; k++) begin
            check("fill_ready", 32'(u_if.updReady), (k <= 7) ? 32'd1 : 32'd0);
            chk_write();
            set_port(0, 9'(16 + 2 * k), 1'b1, 2'd1);
            set_port(1, 9'(17 + 2 * k), 1'b0, 2'd1);
            nxt();
        end
        clear_in();
        check("ov_overflow", 32'(u_if.overflow), 32'd1);
        for (int k = 0; k < 20; k++) begin
            chk_write();
            nxt();
        end
        check("ov_writes", 32'(p), 32'd14);
        check("ov_sticky", 32'(u_if.overflow), 32'd1);

        // reset with 3 entries queued
        set_port(0, 9'd400, 1'b1, 2'd0);
        set_port(1, 9'd401, 1'b1, 2'd0);
        nxt();
        set_port(0, 9'd402, 1'b1, 2'd0);
        set_port(1, 9'd403, 1'b1, 2'd0);
        nxt();
        clear_in();
        rst = 1'b0;
        #1;
        check("rstq_initBusy", 32'(u_if.initBusy), 32'd1);
        check("rstq_wa",       32'(u_if.tblWA),    32'd0);
        check("rstq_overflow", 32'(u_if.overflow), 32'd0);
        check("rstq_ready",    32'(u_if.updReady), 32'd0);
        nxt();
        rst = 1'b1;

        // sweep to 100, with an update dropped during INIT
        for (int i = 0; i < 100; i++) begin
            check("sweep1_wa", 32'(u_if.tblWA), 32'(i));
            if (i == 51) check("init_drop_overflow", 32'(u_if.overflow), 32'd1);
            clear_in();
            if (i == 50) set_port(0, 9'd450, 1'b1, 2'd0);
            nxt();
        end
        check("mid_wa", 32'(u_if.tblWA), 32'd100);
        rst = 1'b0;
        #1;
        check("mid_rst_wa",       32'(u_if.tblWA),    32'd0);
        check("mid_rst_overflow", 32'(u_if.overflow), 32'd0);
        nxt();
        rst = 1'b1;
        for (int i = 0; i < 512; i++) begin
            check("sweep2_wa", 32'(u_if.tblWA), 32'(i));
            check("sweep2_we", 32'(u_if.tblWE), 32'd1);
            nxt();
        end
        check("post_initBusy", 32'(u_if.initBusy), 32'd0);
        check("post_ready",    32'(u_if.updReady), 32'd1);
        for (int k = 0; k < 6; k++) begin
            check("post_no_stale_write", 32'(u_if.tblWE), 32'd0);
            nxt();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
